// File: rtl/cache_types_pkg.sv
// Shared types for the cache controller: FSM state encoding and
// the mux-select encodings it drives into the datapath.
package cache_types_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WRITEBACK = 3'd2,
      S_ALLOCATE  = 3'd3,
      S_REFETCH   = 3'd4
   } state_t;

   localparam logic ADDR_CPU  = 1'b0;
   localparam logic ADDR_TAG  = 1'b1;
   localparam logic DATA_CPU  = 1'b0;
   localparam logic DATA_PMEM = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for cache hit/miss statistics.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/cache_control.sv
// Write-back cache controller FSM: lookup, dirty writeback, line
// allocate and refetch, plus hit/miss performance counters.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | wait for CPU request, read arrays for its set
// LOOKUP    | tag compare; hit completes, miss picks victim path
// WRITEBACK | dirty victim line written to pmem at stored tag
// ALLOCATE  | new line read from pmem and loaded into arrays
// REFETCH   | re-read arrays so the next LOOKUP hits
module cache_control
   import cache_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   input  logic             hit,
   input  logic             valid_out,
   input  logic             dirty_out,
   output logic             array_read,
   output logic             tag_load,
   output logic             valid_load,
   output logic             dirty_load,
   output logic             data_load,
   output logic             dirty_in,
   output logic             data_sel,
   output logic             addr_sel,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   state_t state, state_next;
   logic   hit_inc, miss_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Outputs are gated by rst_n so they drop the instant reset asserts,
   // even while a combinational input (mem_read) is still high.
   always_comb begin
      state_next = state;
      mem_resp   = 1'b0;
      array_read = 1'b0;
      tag_load   = 1'b0;
      valid_load = 1'b0;
      dirty_load = 1'b0;
      data_load  = 1'b0;
      dirty_in   = 1'b0;
      data_sel   = DATA_CPU;
      addr_sel   = ADDR_CPU;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      if (rst_n) begin
         unique case (state)
            S_IDLE: begin
               if (mem_read || mem_write) begin
                  array_read = 1'b1;
                  state_next = S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  mem_resp   = 1'b1;
                  hit_inc    = 1'b1;
                  state_next = S_IDLE;
                  if (mem_write) begin
                     data_load  = 1'b1;
                     data_sel   = DATA_CPU;
                     dirty_load = 1'b1;
                     dirty_in   = 1'b1;
                  end
               end else begin
                  miss_inc   = 1'b1;
                  state_next = (valid_out && dirty_out) ? S_WRITEBACK : S_ALLOCATE;
               end
            end
            S_WRITEBACK: begin
               pmem_write = 1'b1;
               addr_sel   = ADDR_TAG;
               if (pmem_resp)
                  state_next = S_ALLOCATE;
            end
            S_ALLOCATE: begin
               pmem_read = 1'b1;
               addr_sel  = ADDR_CPU;
               if (pmem_resp) begin
                  data_load  = 1'b1;
                  data_sel   = DATA_PMEM;
                  tag_load   = 1'b1;
                  valid_load = 1'b1;
                  dirty_load = 1'b1;
                  dirty_in   = 1'b0;
                  state_next = S_REFETCH;
               end
            end
            S_REFETCH: begin
               array_read = 1'b1;
               state_next = S_LOOKUP;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: randomized transactions against a
// transaction-level model, plus reset and stray-response scenarios.
module tb_cache_control;

   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_read = 1'b0, mem_write = 1'b0, mem_resp;
   logic hit = 1'b0, valid_out = 1'b0, dirty_out = 1'b0;
   logic array_read, tag_load, valid_load, dirty_load, data_load, dirty_in;
   logic data_sel, addr_sel, pmem_read, pmem_write;
   logic pmem_resp = 1'b0;
   logic [CNT_W-1:0] hit_count, miss_count;

   cache_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(mem_resp), .hit(hit), .valid_out(valid_out), .dirty_out(dirty_out),
      .array_read(array_read), .tag_load(tag_load), .valid_load(valid_load),
      .dirty_load(dirty_load), .data_load(data_load), .dirty_in(dirty_in),
      .data_sel(data_sel), .addr_sel(addr_sel), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lat;
      bit is_write;
      bit was_hit;
      bit wb;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0, issue_cyc = 0;
   int   wb_lat = 1, al_lat = 1;
   bit   en_resp = 1'b1, abort = 1'b0;
   bit   wb_seen, al_seen, order_bad, wb_addr_bad, al_addr_bad;
   int   exp_hit = 0, exp_miss = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic logic [10:0] out_vec();
      return {mem_resp, array_read, tag_load, valid_load, dirty_load, data_load,
              dirty_in, data_sel, addr_sel, pmem_read, pmem_write};
   endfunction

   // Physical memory and datapath stand-in: answers after a set latency and
   // reports a hit once the missing line has been brought in.
   int pcnt = 0;
   always @(negedge clk) begin
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write)
         check("pmem_exclusive", {31'd0, pmem_read & pmem_write}, 0);
      if (pmem_write) begin
         wb_seen = 1'b1;
         if (al_seen) order_bad = 1'b1;
         if (addr_sel !== 1'b1) wb_addr_bad = 1'b1;
      end
      if (pmem_read) begin
         al_seen = 1'b1;
         if (addr_sel !== 1'b0) al_addr_bad = 1'b1;
      end
      if (!en_resp) pcnt = 0;
      else if (pmem_read || pmem_write) begin
         pcnt++;
         if (pcnt >= (pmem_write ? wb_lat : al_lat)) begin
            pmem_resp = 1'b1;
            pcnt = 0;
            if (pmem_read) hit = 1'b1;
         end
      end
   end

   bit cnt_pend = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (cnt_pend) begin
         check("hit_count", {28'd0, hit_count}, exp_hit);
         check("miss_count", {28'd0, miss_count}, exp_miss);
         cnt_pend = 1'b0;
      end
      if (mem_resp) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("latency", cyc - issue_cyc + 1, e.lat);
            check("data_load", {31'd0, data_load}, {31'd0, e.is_write});
            check("dirty_load", {31'd0, dirty_load}, {31'd0, e.is_write});
            check("dirty_in", {31'd0, dirty_in}, {31'd0, e.is_write});
            if (e.is_write) check("data_sel_cpu", {31'd0, data_sel}, 0);
            check("wb_seen", {31'd0, wb_seen}, {31'd0, e.wb});
            check("alloc_seen", {31'd0, al_seen}, {31'd0, !e.was_hit});
            check("pmem_order_addr", {29'd0, order_bad, wb_addr_bad, al_addr_bad}, 0);
            check("pmem_idle_at_resp", {30'd0, pmem_read, pmem_write}, 0);
            exp_hit  = (exp_hit < MAXC) ? exp_hit + 1 : MAXC;
            if (!e.was_hit) exp_miss = (exp_miss < MAXC) ? exp_miss + 1 : MAXC;
            cnt_pend = 1'b1;
         end
      end
   end

   // kind: 0 read, 1 write, 2 read+write (behaves as write)
   task automatic issue(input int kind, input bit h, input bit v, input bit d,
                        input int wl, input int al);
      exp_t e;
      int n;
      e.is_write = (kind != 0);
      e.was_hit  = h;
      e.wb       = !h && v && d;
      e.lat      = h ? 2 : (4 + al + (e.wb ? wl : 0));
      exp_q.push_back(e);
      wb_seen = 0; al_seen = 0; order_bad = 0; wb_addr_bad = 0; al_addr_bad = 0;
      wb_lat = wl; al_lat = al;
      hit = h; valid_out = v; dirty_out = d;
      issue_cyc = cyc;
      mem_read  = (kind != 1);
      mem_write = (kind != 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_resp && n < 400);
      if (!mem_resp) begin
         check("resp_timeout", n, 0);
         abort = 1'b1;
      end
      @(negedge clk);
      mem_read = 0; mem_write = 0; hit = 0;
   endtask

   int dir_tab[3][6] = '{
      '{0, 1, 0, 0, 1, 1},
      '{1, 1, 0, 0, 1, 1},
      '{0, 0, 1, 1, 3, 3}
   };

   initial begin
      int n;
      mem_read = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", {21'd0, out_vec()}, 0);
      check("reset_hit_count", {28'd0, hit_count}, 0);
      check("reset_miss_count", {28'd0, miss_count}, 0);
      rst_n = 1'b1;
      mem_read = 1'b0;

      for (int i = 0; i < 3 && !abort; i++)
         issue(dir_tab[i][0], dir_tab[i][1][0], dir_tab[i][2][0], dir_tab[i][3][0],
               dir_tab[i][4], dir_tab[i][5]);
      for (int i = 0; i < 40 && !abort; i++)
         issue($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4));
      @(negedge clk);
      check("hit_saturated", {28'd0, hit_count}, MAXC);

      // reset while a line fill is outstanding
      en_resp = 1'b0;
      hit = 0; valid_out = 0; dirty_out = 0; mem_read = 1'b1;
      n = 0;
      while (!pmem_read && n < 20) begin @(negedge clk); n++; end
      check("alloc_reached", {31'd0, pmem_read}, 1);
      rst_n = 1'b0;
      #1;
      check("rst_drops_outputs", {21'd0, out_vec()}, 0);
      check("rst_hit_count", {28'd0, hit_count}, 0);
      check("rst_miss_count", {28'd0, miss_count}, 0);
      exp_hit = 0; exp_miss = 0;
      @(negedge clk);
      mem_read = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {21'd0, out_vec()}, 0);

      // stray pmem response while idle
      pmem_resp = 1'b1;
      @(negedge clk);
      check("stray_resp_outputs", {21'd0, out_vec()}, 0);
      @(negedge clk);
      check("stray_resp_outputs2", {21'd0, out_vec()}, 0);
      en_resp = 1'b1;
      if (!abort) issue(0, 1, 0, 0, 1, 1);
      if (!abort) issue(1, 0, 1, 0, 2, 2);
      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
